// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fifo_write_arbiter
// Description : Shares the enqueue side of one mixed_clock_fifo between
//               NUM_PORTS producers. Round-robin arbitration with up to BURST
//               tokens per grant. It never overfills the FIFO because it
//               tracks the FIFO population plus the one enqueue in flight.
//               It also sequences a FIFO flush on request. Everything runs in
//               the FIFO write-clock domain.
// Ports       : clock, reset        - write clock, synchronous active-high reset
//               request/data_in     - per-port token offer; port i data sits at
//                                     [i*BIT_WIDTH +: BIT_WIDTH]
//               flush_request       - one-cycle pulse that starts a FIFO flush
//               population          - FIFO population (write-domain view)
//               grant               - combinational, one-hot or zero; the token
//                                     is taken at this clock edge
//               fifo_data_in/enqueue/flush - registered FIFO controls
//               busy                - registered, high while not idle
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_write_arbiter #(
    parameter int NUM_PORTS = 4,
    parameter int BIT_WIDTH = 16,
    parameter int CAPACITY  = 5,
    parameter int BURST     = 2,
    parameter int FLUSH_LEN = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            request,
    input  logic [NUM_PORTS*BIT_WIDTH-1:0]  data_in,
    input  logic                            flush_request,
    input  logic [$clog2(CAPACITY+1)-1:0]   population,
    output logic [NUM_PORTS-1:0]            grant,
    output logic [BIT_WIDTH-1:0]            fifo_data_in,
    output logic                            fifo_enqueue,
    output logic                            fifo_flush,
    output logic                            busy
);

    localparam int C_PTR_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int C_IDX_W   = C_PTR_W + 1;
    localparam int C_POP_W   = $clog2(CAPACITY + 1);
    localparam int C_LVL_W   = C_POP_W + 1;
    localparam int C_BURST_W = $clog2(BURST + 1);
    localparam int C_FLUSH_W = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                 r_state;
    logic [C_PTR_W-1:0]     r_rr_ptr;
    logic [C_PTR_W-1:0]     r_cur;
    logic [C_BURST_W-1:0]   r_burst_cnt;
    logic [C_FLUSH_W-1:0]   r_flush_cnt;
    logic [BIT_WIDTH-1:0]   r_fifo_data_in;
    logic                   r_fifo_enqueue;
    logic                   r_fifo_flush;
    logic                   r_busy;

    state_t                 w_next_state;
    logic [C_PTR_W-1:0]     w_next_ptr;
    logic [C_PTR_W-1:0]     w_next_cur;
    logic [C_BURST_W-1:0]   w_next_burst;
    logic [C_FLUSH_W-1:0]   w_next_flush_cnt;
    logic                   w_take;
    logic [C_PTR_W-1:0]     w_take_port;
    logic [BIT_WIDTH-1:0]   w_take_data;
    logic                   w_found;
    logic [C_PTR_W-1:0]     w_winner;
    logic [C_IDX_W-1:0]     w_idx;
    logic [C_LVL_W-1:0]     w_level;
    logic                   w_space;

    function automatic logic [C_PTR_W-1:0] f_next_port(input logic [C_PTR_W-1:0] p);
        if (p == C_PTR_W'(NUM_PORTS - 1)) begin
            return '0;
        end
        return p + C_PTR_W'(1);
    endfunction

    // The enqueue currently on the FIFO port has not reached population yet,
    // so it counts as occupied. One extra bit keeps the sum from wrapping.
    assign w_level = {1'b0, population} + {{C_POP_W{1'b0}}, r_fifo_enqueue};
    assign w_space = (w_level < C_LVL_W'(CAPACITY));

    // Find the first requesting port at or after the round-robin pointer.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            w_idx = {1'b0, r_rr_ptr} + C_IDX_W'(k);
            if (w_idx >= C_IDX_W'(NUM_PORTS)) begin
                w_idx = w_idx - C_IDX_W'(NUM_PORTS);
            end
            if (!w_found && request[w_idx[C_PTR_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_idx[C_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_ptr       = r_rr_ptr;
        w_next_cur       = r_cur;
        w_next_burst     = r_burst_cnt;
        w_next_flush_cnt = r_flush_cnt;
        w_take           = 1'b0;
        w_take_port      = r_cur;
        case (r_state)
            ST_IDLE: begin
                if (flush_request) begin
                    w_next_state     = ST_FLUSH;
                    w_next_flush_cnt = '0;
                end else if (w_space && w_found) begin
                    w_take       = 1'b1;
                    w_take_port  = w_winner;
                    w_next_cur   = w_winner;
                    w_next_burst = C_BURST_W'(1);
                    if (BURST == 1) begin
                        w_next_ptr = f_next_port(w_winner);
                    end else begin
                        w_next_state = ST_SERVE;
                    end
                end
            end
            ST_SERVE: begin
                // A flush aborts the burst and hands priority to the next port.
                if (flush_request) begin
                    w_next_ptr       = f_next_port(r_cur);
                    w_next_state     = ST_FLUSH;
                    w_next_flush_cnt = '0;
                end else if (request[r_cur] && w_space &&
                             (r_burst_cnt < C_BURST_W'(BURST))) begin
                    w_take       = 1'b1;
                    w_next_burst = r_burst_cnt + C_BURST_W'(1);
                    if (r_burst_cnt == C_BURST_W'(BURST - 1)) begin
                        w_next_ptr   = f_next_port(r_cur);
                        w_next_state = ST_IDLE;
                    end
                end else if (!request[r_cur]) begin
                    w_next_ptr   = f_next_port(r_cur);
                    w_next_state = ST_IDLE;
                end
                // Otherwise the FIFO is full: keep the burst open and wait.
            end
            ST_FLUSH: begin
                if (r_flush_cnt == C_FLUSH_W'(FLUSH_LEN - 1)) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_flush_cnt = r_flush_cnt + C_FLUSH_W'(1);
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign w_take_data = data_in[w_take_port*BIT_WIDTH +: BIT_WIDTH];

    always_comb begin
        grant = '0;
        if (w_take && !reset) begin
            grant[w_take_port] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= ST_IDLE;
            r_rr_ptr       <= '0;
            r_cur          <= '0;
            r_burst_cnt    <= '0;
            r_flush_cnt    <= '0;
            r_fifo_data_in <= '0;
            r_fifo_enqueue <= 1'b0;
            r_fifo_flush   <= 1'b0;
            r_busy         <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_rr_ptr       <= w_next_ptr;
            r_cur          <= w_next_cur;
            r_burst_cnt    <= w_next_burst;
            r_flush_cnt    <= w_next_flush_cnt;
            r_fifo_enqueue <= w_take;
            if (w_take) begin
                r_fifo_data_in <= w_take_data;
            end
            // Flush and busy track the state being entered so that they line
            // up cycle-for-cycle with the registered state.
            r_fifo_flush   <= (w_next_state == ST_FLUSH);
            r_busy         <= (w_next_state != ST_IDLE);
        end
    end

    assign fifo_data_in = r_fifo_data_in;
    assign fifo_enqueue = r_fifo_enqueue;
    assign fifo_flush   = r_fifo_flush;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_fifo_write_arbiter
// Description : Self-checking bench for fifo_write_arbiter. It runs directed
//               scenarios followed by randomized traffic against a behavioural
//               model and a FIFO occupancy model. Enqueued tokens are scored
//               through a queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_write_arbiter;

    localparam int N     = 4;
    localparam int W     = 16;
    localparam int CAP   = 5;
    localparam int BURST = 2;
    localparam int FLEN  = 2;
    localparam int POPW  = $clog2(CAP + 1);

    localparam int M_IDLE  = 0;
    localparam int M_SERVE = 1;
    localparam int M_FLUSH = 2;

    logic               clock = 1'b0;
    logic               reset;
    logic [N-1:0]       request;
    logic [N*W-1:0]     data_in;
    logic               flush_request;
    logic [POPW-1:0]    population;
    logic [N-1:0]       grant;
    logic [W-1:0]       fifo_data_in;
    logic               fifo_enqueue;
    logic               fifo_flush;
    logic               busy;

    always #5 clock = ~clock;

    fifo_write_arbiter #(
        .NUM_PORTS (N),
        .BIT_WIDTH (W),
        .CAPACITY  (CAP),
        .BURST     (BURST),
        .FLUSH_LEN (FLEN)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .request       (request),
        .data_in       (data_in),
        .flush_request (flush_request),
        .population    (population),
        .grant         (grant),
        .fifo_data_in  (fifo_data_in),
        .fifo_enqueue  (fifo_enqueue),
        .fifo_flush    (fifo_flush),
        .busy          (busy)
    );

    typedef struct {
        logic [W-1:0] data;
        int           cyc;
    } tok_t;

    tok_t   sb[$];
    tok_t   mon_t;
    int     n_vec = 0;
    int     n_err = 0;
    int     cyc   = 0;
    bit     armed = 1'b0;

    // Reference model of the arbiter's externally visible behaviour.
    int     m_mode = M_IDLE, m_ptr = 0, m_cur = 0, m_taken = 0, m_left = 0;
    bit     m_enq = 1'b0, m_fl = 1'b0, m_busy = 1'b0;
    int     pop = 0;

    logic [N-1:0]   req_v;
    logic [W-1:0]   data_v [N];
    bit             rand_mode = 1'b0;
    int             p_req = 0, p_drop = 0, p_deq = 0;
    bit             deq_now;
    int             exp_gnt;

    logic [N-1:0]   obs_grant;
    logic           obs_enq, obs_flush, obs_busy;
    logic [W-1:0]   obs_data;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic int predict(input bit rst, input bit fl);
        bit space;
        space = (pop + int'(m_enq)) < CAP;
        if (rst || fl || !space) return -1;
        if (m_mode == M_IDLE) begin
            for (int k = 0; k < N; k++) begin
                if (req_v[(m_ptr + k) % N]) return (m_ptr + k) % N;
            end
        end else if (m_mode == M_SERVE && req_v[m_cur] && m_taken < BURST) begin
            return m_cur;
        end
        return -1;
    endfunction

    task automatic commit(input bit rst, input bit fl, input int g);
        // FIFO occupancy evolves from what the arbiter showed before this edge.
        if (m_fl) pop = 0;
        else begin
            if (deq_now && pop > 0) pop--;
            if (m_enq) pop++;
        end
        cyc++;
        if (rst) begin
            m_mode = M_IDLE; m_ptr = 0; m_cur = 0; m_taken = 0; m_left = 0;
            m_enq = 1'b0; m_fl = 1'b0; m_busy = 1'b0;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    if (fl) begin
                        m_mode = M_FLUSH; m_left = FLEN;
                    end else if (g >= 0) begin
                        m_cur = g; m_taken = 1;
                        if (BURST == 1) m_ptr = (g + 1) % N;
                        else m_mode = M_SERVE;
                    end
                end
                M_SERVE: begin
                    if (fl) begin
                        m_ptr = (m_cur + 1) % N; m_mode = M_FLUSH; m_left = FLEN;
                    end else if (g >= 0) begin
                        m_taken++;
                        if (m_taken == BURST) begin
                            m_ptr = (m_cur + 1) % N; m_mode = M_IDLE;
                        end
                    end else if (!req_v[m_cur]) begin
                        m_ptr = (m_cur + 1) % N; m_mode = M_IDLE;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) m_mode = M_IDLE;
                end
            endcase
            m_enq = (g >= 0);
            if (g >= 0) begin
                mon_t.data = data_v[g];
                mon_t.cyc  = cyc;
                sb.push_back(mon_t);
            end
            m_fl   = (m_mode == M_FLUSH);
            m_busy = (m_mode != M_IDLE);
        end
        // Producers: a consumed token is replaced; data only changes while idle.
        for (int i = 0; i < N; i++) begin
            if (g == i) begin
                data_v[i] = W'($urandom);
                if (rand_mode && $urandom_range(99) < p_drop) req_v[i] = 1'b0;
            end else if (rand_mode) begin
                if (req_v[i]) begin
                    if ($urandom_range(99) < p_drop / 2) req_v[i] = 1'b0;
                end else if ($urandom_range(99) < p_req) begin
                    req_v[i]  = 1'b1;
                    data_v[i] = W'($urandom);
                end
            end
        end
    endtask

    task automatic run_cycle(input bit rst, input bit fl);
        reset         = rst;
        flush_request = fl;
        request       = req_v;
        for (int i = 0; i < N; i++) data_in[i*W +: W] = data_v[i];
        population    = POPW'(pop);
        deq_now       = ($urandom_range(99) < p_deq);
        exp_gnt       = predict(rst, fl);
        @(negedge clock);
        obs_grant = grant;
        obs_enq   = fifo_enqueue;
        obs_flush = fifo_flush;
        obs_busy  = busy;
        obs_data  = fifo_data_in;
        if (armed) begin
            check("grant", 32'(grant), (exp_gnt < 0) ? 32'd0 : (32'd1 << exp_gnt));
            check("fifo_enqueue", 32'(fifo_enqueue), 32'(m_enq));
            check("fifo_flush", 32'(fifo_flush), 32'(m_fl));
            check("busy", 32'(busy), 32'(m_busy));
        end
        @(posedge clock);
        commit(rst, fl, exp_gnt);
        #1;
    endtask

    // Scoreboard monitor: every enqueue shown by the DUT must match the next
    // expected token, in the cycle the model predicted.
    always @(negedge clock) begin
        if (armed) begin
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                n_vec++;
                n_err++;
                $display("FAIL missing_enqueue: got none expected data %0h (cycle %0d)", sb[0].data, sb[0].cyc);
                void'(sb.pop_front());
            end
            if (fifo_enqueue === 1'b1) begin
                n_vec++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_enqueue: got data %0h expected no enqueue (cycle %0d)", fifo_data_in, cyc);
                end else begin
                    mon_t = sb.pop_front();
                    if (mon_t.cyc != cyc || mon_t.data !== fifo_data_in) begin
                        n_err++;
                        $display("FAIL enqueue_data: got %0h at cycle %0d expected %0h at cycle %0d",
                                 fifo_data_in, cyc, mon_t.data, mon_t.cyc);
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] rr_exp [8];
    int           cnt;
    bit           prev_fl;

    initial begin
        rr_exp = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100, 4'b1000, 4'b1000};
        for (int i = 0; i < N; i++) data_v[i] = W'($urandom);

        // Reset held three cycles with every port requesting.
        req_v = '1;
        p_deq = 0;
        run_cycle(1'b1, 1'b0);
        armed = 1'b1;
        run_cycle(1'b1, 1'b0);
        run_cycle(1'b1, 1'b0);
        check("reset_grant", 32'(obs_grant), 32'd0);
        check("reset_enqueue", 32'(obs_enq), 32'd0);
        check("reset_flush", 32'(obs_flush), 32'd0);
        check("reset_busy", 32'(obs_busy), 32'd0);
        check("reset_data", 32'(obs_data), 32'd0);

        // Round robin with bursts of two while the FIFO drains.
        p_deq = 100;
        for (int i = 0; i < 8; i++) begin
            run_cycle(1'b0, 1'b0);
            check("rr_sequence", 32'(obs_grant), 32'(rr_exp[i]));
        end

        // Fill the FIFO with no dequeue: exactly CAPACITY grants.
        req_v = '0;
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0);
        req_v = '1;
        p_deq = 0;
        cnt   = 0;
        for (int i = 0; i < 15; i++) begin
            run_cycle(1'b0, 1'b0);
            if (obs_grant != '0) cnt++;
        end
        check("full_grant_count", 32'(cnt), 32'(CAP));
        p_deq = 100;
        cnt   = 0;
        run_cycle(1'b0, 1'b0);
        if (obs_grant != '0) cnt++;
        p_deq = 0;
        for (int i = 0; i < 6; i++) begin
            run_cycle(1'b0, 1'b0);
            if (obs_grant != '0) cnt++;
        end
        check("full_after_dequeue", 32'(cnt), 32'd1);

        // Flush in the middle of a burst on port 1.
        req_v = '0;
        p_deq = 100;
        for (int i = 0; i < 8; i++) run_cycle(1'b0, 1'b0);
        req_v = 4'b0010;
        run_cycle(1'b0, 1'b0);
        check("flush_first_grant", 32'(obs_grant), 32'h2);
        run_cycle(1'b0, 1'b1);
        check("flush_edge_grant", 32'(obs_grant), 32'd0);
        req_v = '1;
        for (int i = 0; i < FLEN; i++) begin
            run_cycle(1'b0, 1'b0);
            check("flush_active", 32'(obs_flush), 32'd1);
            check("flush_no_grant", 32'(obs_grant), 32'd0);
        end
        run_cycle(1'b0, 1'b0);
        check("flush_done", 32'(obs_flush), 32'd0);
        check("flush_next_grant", 32'(obs_grant), 32'h4);

        // Reset while serving with an enqueue in flight.
        req_v = 4'b0100;
        run_cycle(1'b0, 1'b0);
        run_cycle(1'b0, 1'b0);
        req_v = '1;
        run_cycle(1'b1, 1'b0);
        check("midreset_enqueue_before", 32'(obs_enq), 32'd1);
        check("midreset_grant", 32'(obs_grant), 32'd0);
        run_cycle(1'b0, 1'b0);
        check("midreset_enqueue_after", 32'(obs_enq), 32'd0);
        check("midreset_busy_after", 32'(obs_busy), 32'd0);
        check("midreset_data_after", 32'(obs_data), 32'd0);
        check("midreset_next_grant", 32'(obs_grant), 32'h1);

        // Randomized traffic in three pressure regimes.
        rand_mode = 1'b1;
        prev_fl   = 1'b0;
        for (int ph = 0; ph < 3; ph++) begin
            int p_fl, p_rst;
            case (ph)
                0:       begin p_req = 60; p_drop = 10; p_deq = 50; p_fl = 2; p_rst = 1; end
                1:       begin p_req = 90; p_drop = 3;  p_deq = 20; p_fl = 1; p_rst = 0; end
                default: begin p_req = 30; p_drop = 30; p_deq = 80; p_fl = 5; p_rst = 2; end
            endcase
            for (int i = 0; i < 600; i++) begin
                bit fl, rs;
                fl = !prev_fl && ($urandom_range(99) < p_fl);
                rs = ($urandom_range(99) < p_rst);
                run_cycle(rs, fl);
                prev_fl = fl;
            end
        end

        rand_mode = 1'b0;
        req_v     = '0;
        p_deq     = 100;
        for (int i = 0; i < 4; i++) run_cycle(1'b0, 1'b0);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
